dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter: DEPTH, 256, number of 64-bit words (power of two, 2..4096).
REQ-002 SHALL have parameter: ADDR_W, log2(DEPTH), word-index width; derived, not overridden.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: memEn  input  1  access request, one per cycle.
REQ-006 SHALL have port: memWrEn  input  1  1 = write, 0 = read; ignored unless memEn=1.
REQ-007 SHALL have port: addr_in  input  32 ([0:31])  word address; bit 31 is the LSB.
REQ-008 SHALL have port: wr_data  input  64 ([0:63])  write data.
REQ-009 SHALL have port: rd_data  output  64 ([0:63])  read data, registered.
REQ-010 SHALL have port: rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-011 SHALL have port: mem_ready  output  1  1 = requests accepted this cycle.
REQ-012 SHALL have port: acc_err  output  1  one-cycle pulse: rejected or out-of-range request.
REQ-013 SHALL have port: par_err  output  1  one-cycle pulse with rd_valid: parity mismatch.

Function
REQ-014 SHALL implement FSM states INIT and READY; reset enters INIT.
REQ-015 SHALL, in INIT, clear word i (data and parity) at cycle i after reset release, i = 0..DEPTH-1, via a clear counter.
REQ-016 SHALL hold mem_ready=0 in INIT, move to READY the cycle after word DEPTH-1 is cleared, and keep mem_ready=1 in READY.
REQ-017 SHALL, for memEn=1 while mem_ready=0, drop the request, leave the array untouched, and pulse acc_err next cycle.
REQ-018 SHALL accept a request at cycle T when memEn=1 and mem_ready=1.
REQ-019 SHALL treat an accepted request with addr_in >= DEPTH as out-of-range: no write, no rd_valid, acc_err pulse at T+1.
REQ-020 SHALL commit an in-range accepted write at the clock edge ending cycle T; no response pulse.
REQ-021 SHALL return an in-range accepted read at T+2: rd_valid=1 for exactly one cycle, with rd_data = word content after all writes accepted before T.
REQ-022 SHALL make a write at T visible to a read of the same address accepted at T+1, with no bubble.
REQ-023 SHALL sustain back-to-back reads at one per cycle, keeping two reads in flight in order.
REQ-024 SHALL hold rd_data at its last returned value when rd_valid=0.
REQ-025 SHALL use addr_in[32-ADDR_W:31] as the word index; higher bits set means out-of-range.

Reset
REQ-026 SHALL, on reset=0 at a clock edge, drive rd_data=0, rd_valid=0, mem_ready=0, acc_err=0, par_err=0 in the following cycle.
REQ-027 SHALL discard in-flight reads on reset mid-operation: no rd_valid pulse, counter to 0, FSM to INIT.
REQ-028 SHALL restart the full INIT clear after every reset; array contents are not preserved.

Configuration
REQ-029 SHALL, with DMEM_PARITY_EN defined, store an even-parity bit per word on write and INIT.
REQ-030 SHALL, with DMEM_PARITY_EN defined, recompute parity on read and pulse par_err with rd_valid on mismatch; rd_data is still returned.
REQ-031 SHALL, without DMEM_PARITY_EN, store no parity bit and tie par_err to 0.

Structure
REQ-032 SHALL place DATA_W=64, the default DEPTH, and the INIT/READY state encoding in shared package dmem_pkg.
REQ-033 SHALL use one sub-module, dmem_array: a single-port synchronous-write, registered-read storage array, with the parity bit under DMEM_PARITY_EN.

Verification
REQ-034 SHALL cover INIT: release reset; mem_ready=0 for DEPTH cycles, then 1; read of address 5 -> rd_data=0 at T+2.
REQ-035 SHALL cover write-then-read: write 0x0123456789ABCDEF to address 3 at T, read address 3 at T+1 -> rd_valid and that value at T+3.
REQ-036 SHALL cover streaming: reads of addresses 0,1,2 on consecutive cycles after writes 0xA,0xB,0xC -> rd_valid on three consecutive cycles with 0xA,0xB,0xC in order.
REQ-037 SHALL cover errors: read with addr_in=DEPTH -> acc_err pulse at T+1, no rd_valid; a write during INIT -> acc_err pulse, and the target word reads 0 afterwards.
REQ-038 SHALL cover reset mid-read: reset=0 at T+1 after a read at T -> no rd_valid at T+2, mem_ready=0, INIT restarts.
REQ-039 SHALL cover parity (DMEM_PARITY_EN): force-flip a stored data bit, then read -> par_err=1 with rd_valid; without the macro par_err stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int DATA_W        = 64;
    localparam int DEFAULT_DEPTH = 256;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port storage array: synchronous write, registered read.
// With DMEM_PARITY_EN defined, a parity bit is stored alongside each word.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
`ifdef DMEM_PARITY_EN
    ,
    input  logic              wpar,
    output logic              rpar
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end

`ifdef DMEM_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            par[addr] <= wpar;
        else if (re)
            rpar <= par[addr];
    end
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: INIT clear sweep, then one request per cycle with
// two-cycle read latency. Optional parity checking under DMEM_PARITY_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memEn,
    input  logic        memWrEn,
    input  logic [0:31] addr_in,
    input  logic [0:63] wr_data,
    output logic [0:63] rd_data,
    output logic        rd_valid,
    output logic        mem_ready,
    output logic        acc_err,
    output logic        par_err
);

    localparam int STAGES = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [STAGES:0]   vld_pipe;

    logic [31:0]       addr_num;
    logic [ADDR_W-1:0] idx;
    logic              in_range, clearing, hit;
    logic              arr_we, arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    // addr_in is big-endian numbered; a plain copy keeps the numeric value.
    assign addr_num  = addr_in;
    assign idx       = addr_num[ADDR_W-1:0];
    assign in_range  = addr_num < 32'(DEPTH);
    assign mem_ready = (state == ST_READY);
    assign clearing  = (state == ST_INIT) && reset;
    assign hit       = memEn && mem_ready && in_range;

    assign arr_we    = clearing || (hit && memWrEn);
    assign arr_re    = hit && !memWrEn;
    assign arr_addr  = clearing ? clr_cnt : idx;
    assign arr_wdata = clearing ? '0 : wr_data;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)
                clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    // vld_pipe[0]: array read in flight; vld_pipe[STAGES]: data on rd_data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe <= '0;
            acc_err  <= 1'b0;
            rd_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], arr_re};
            acc_err  <= memEn && (!mem_ready || !in_range);
            if (vld_pipe[0])
                rd_data <= arr_rdata;
        end
    end

    assign rd_valid = vld_pipe[STAGES];

`ifdef DMEM_PARITY_EN
    logic arr_wpar, arr_rpar;

    assign arr_wpar = clearing ? 1'b0 : even_par(wr_data);

    always_ff @(posedge clk) begin
        if (!reset)
            par_err <= 1'b0;
        else
            par_err <= vld_pipe[0] && (even_par(arr_rdata) != arr_rpar);
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata),
        .wpar  (arr_wpar),
        .rpar  (arr_rpar)
    );
`else
    assign par_err = 1'b0;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic checked
// against a word-array / response-queue model. Honors DMEM_PARITY_EN.
module tb_dmem_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memEn = 1'b0;
    logic        memWrEn = 1'b0;
    logic [31:0] addr_in = '0;
    logic [63:0] wr_data = '0;
    logic [63:0] rd_data;
    logic        rd_valid, mem_ready, acc_err, par_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .memEn     (memEn),
        .memWrEn   (memWrEn),
        .addr_in   (addr_in),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .mem_ready (mem_ready),
        .acc_err   (acc_err),
        .par_err   (par_err)
    );

    // Reference model: word contents, pending responses keyed by due cycle.
    typedef struct { int due; logic [63:0] d; } rsp_t;

    int          ntest = 0, nfail = 0;
    int          cyc = 0, ready_cyc = 1 << 30;
    logic [63:0] mdl [DEPTH];
    rsp_t        rq[$];
    int          aq[$];
    logic [63:0] last_rd = '0;
    logic        e_rv = 1'b0, e_acc = 1'b0, e_rdy = 1'b0;
    logic [63:0] e_rd = '0;

    // Drive one cycle of inputs, advance the model, land on the next negedge.
    task automatic step(input logic rn, input logic en, input logic we,
                        input logic [31:0] a, input logic [63:0] d);
        reset = rn; memEn = en; memWrEn = we; addr_in = a; wr_data = d;
        if (!rn) begin
            rq.delete();
            aq.delete();
            last_rd = '0;
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            ready_cyc = cyc + 1 + DEPTH;
        end else if (en) begin
            if (!e_rdy || a >= 32'(DEPTH)) aq.push_back(cyc + 1);
            else if (we) mdl[int'(a)] = d;
            else rq.push_back('{cyc + 2, mdl[int'(a)]});
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        e_rv = (rq.size() > 0 && rq[0].due == cyc);
        if (e_rv) begin
            last_rd = rq[0].d;
            void'(rq.pop_front());
        end
        e_rd  = last_rd;
        e_acc = (aq.size() > 0 && aq[0] == cyc);
        if (e_acc) void'(aq.pop_front());
        e_rdy = (cyc >= ready_cyc);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b1, 1'b0, 32'd1, '0);
        ntest += 5;
        if (rd_data !== 64'd0) begin nfail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        if (rd_valid !== 1'b0) begin nfail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        if (mem_ready !== 1'b0) begin nfail++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
        if (acc_err !== 1'b0) begin nfail++; $display("FAIL reset_acc_err: got %b want 0", acc_err); end
        if (par_err !== 1'b0) begin nfail++; $display("FAIL reset_par_err: got %b want 0", par_err); end
    endtask

    task automatic test_init();
        for (int i = 0; i < DEPTH; i++) begin
            ntest++;
            if (mem_ready !== 1'b0) begin nfail++; $display("FAIL init_not_ready[%0d]: got %b want 0", i, mem_ready); end
            idle();
        end
        ntest++;
        if (mem_ready !== 1'b1) begin nfail++; $display("FAIL init_ready: got %b want 1", mem_ready); end
        step(1'b1, 1'b1, 1'b0, 32'd5, '0);
        idle();
        ntest += 2;
        if (rd_valid !== 1'b1) begin nfail++; $display("FAIL init_read_valid: got %b want 1", rd_valid); end
        if (rd_data !== 64'd0) begin nfail++; $display("FAIL init_read_data: got %h want 0", rd_data); end
    endtask

    task automatic test_write_read();
        logic [63:0] v;
        v = 64'h0123456789ABCDEF;
        step(1'b1, 1'b1, 1'b1, 32'd3, v);
        step(1'b1, 1'b1, 1'b0, 32'd3, '0);
        ntest++;
        if (rd_valid !== 1'b0) begin nfail++; $display("FAIL wr_rd_early_valid: got %b want 0", rd_valid); end
        idle();
        ntest += 2;
        if (rd_valid !== 1'b1) begin nfail++; $display("FAIL wr_rd_valid: got %b want 1", rd_valid); end
        if (rd_data !== v) begin nfail++; $display("FAIL wr_rd_data: got %h want %h", rd_data, v); end
        idle();
        ntest += 2;
        if (rd_valid !== 1'b0) begin nfail++; $display("FAIL wr_rd_pulse: got %b want 0", rd_valid); end
        if (rd_data !== v) begin nfail++; $display("FAIL wr_rd_hold: got %h want %h", rd_data, v); end
    endtask

    task automatic test_stream();
        logic [63:0] want;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'(i), 64'hA + 64'(i));
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, 1'b1, 1'b0, 32'(i), '0);
            else idle();
            ntest++;
            if (rd_valid !== (i >= 1 && i <= 3)) begin
                nfail++; $display("FAIL stream_valid[%0d]: got %b want %b", i, rd_valid, (i >= 1 && i <= 3));
            end
            if (i >= 1 && i <= 3) begin
                want = 64'hA + 64'(i - 1);
                ntest++;
                if (rd_data !== want) begin nfail++; $display("FAIL stream_data[%0d]: got %h want %h", i, rd_data, want); end
            end
        end
    endtask

    task automatic test_errors();
        int n;
        step(1'b1, 1'b1, 1'b0, 32'(DEPTH), '0);
        ntest += 2;
        if (acc_err !== 1'b1) begin nfail++; $display("FAIL oor_acc_err: got %b want 1", acc_err); end
        if (rd_valid !== 1'b0) begin nfail++; $display("FAIL oor_valid_t1: got %b want 0", rd_valid); end
        idle();
        ntest += 2;
        if (rd_valid !== 1'b0) begin nfail++; $display("FAIL oor_valid_t2: got %b want 0", rd_valid); end
        if (acc_err !== 1'b0) begin nfail++; $display("FAIL oor_acc_pulse: got %b want 0", acc_err); end
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b1, 1'b1, 32'd7, '1);
        ntest++;
        if (acc_err !== 1'b1) begin nfail++; $display("FAIL init_wr_acc_err: got %b want 1", acc_err); end
        n = 0;
        while (mem_ready !== 1'b1 && n < DEPTH + 8) begin idle(); n++; end
        ntest++;
        if (mem_ready !== 1'b1) begin nfail++; $display("FAIL init_wr_timeout: got %b want 1", mem_ready); end
        step(1'b1, 1'b1, 1'b0, 32'd7, '0);
        idle();
        ntest += 2;
        if (rd_valid !== 1'b1) begin nfail++; $display("FAIL init_wr_read_valid: got %b want 1", rd_valid); end
        if (rd_data !== 64'd0) begin nfail++; $display("FAIL init_wr_read_data: got %h want 0", rd_data); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        step(1'b1, 1'b1, 1'b0, 32'd3, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        ntest += 2;
        if (rd_valid !== 1'b0) begin nfail++; $display("FAIL midrst_valid: got %b want 0", rd_valid); end
        if (mem_ready !== 1'b0) begin nfail++; $display("FAIL midrst_ready: got %b want 0", mem_ready); end
        n = 0;
        while (mem_ready !== 1'b1 && n < DEPTH + 8) begin
            idle(); n++;
            ntest++;
            if (rd_valid !== 1'b0) begin nfail++; $display("FAIL midrst_stray_valid: got %b want 0", rd_valid); end
        end
        ntest++;
        if (n != DEPTH) begin nfail++; $display("FAIL midrst_init_len: got %0d want %0d", n, DEPTH); end
    endtask

    task automatic test_random();
        logic        rn, en, we;
        logic [31:0] a;
        for (int k = 0; k < 400; k++) begin
            rn = ($urandom_range(0, 99) != 0);
            en = ($urandom_range(0, 9) < 7);
            we = $urandom_range(0, 1) == 1;
            a  = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH + 1));
            step(rn, en, we, a, {$urandom(), $urandom()});
            ntest += 5;
            if (rd_valid !== e_rv) begin nfail++; $display("FAIL rand_valid@%0d: got %b want %b", cyc, rd_valid, e_rv); end
            if (rd_data !== e_rd) begin nfail++; $display("FAIL rand_data@%0d: got %h want %h", cyc, rd_data, e_rd); end
            if (acc_err !== e_acc) begin nfail++; $display("FAIL rand_acc@%0d: got %b want %b", cyc, acc_err, e_acc); end
            if (mem_ready !== e_rdy) begin nfail++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, mem_ready, e_rdy); end
            if (par_err !== 1'b0) begin nfail++; $display("FAIL rand_par@%0d: got %b want 0", cyc, par_err); end
        end
    endtask

    task automatic test_parity();
        logic [63:0] v, want;
        int n;
        n = 0;
        while (mem_ready !== 1'b1 && n < DEPTH + 8) begin idle(); n++; end
        v = 64'hDEAD_BEEF_0000_1111;
        step(1'b1, 1'b1, 1'b1, 32'd9, v);
        want = v;
`ifdef DMEM_PARITY_EN
        dut.u_array.mem[9] = dut.u_array.mem[9] ^ 64'h10;
        want = v ^ 64'h10;
`endif
        step(1'b1, 1'b1, 1'b0, 32'd9, '0);
        idle();
        ntest += 3;
        if (rd_valid !== 1'b1) begin nfail++; $display("FAIL par_valid: got %b want 1", rd_valid); end
        if (rd_data !== want) begin nfail++; $display("FAIL par_data: got %h want %h", rd_data, want); end
`ifdef DMEM_PARITY_EN
        if (par_err !== 1'b1) begin nfail++; $display("FAIL par_err_flag: got %b want 1", par_err); end
`else
        if (par_err !== 1'b0) begin nfail++; $display("FAIL par_err_flag: got %b want 0", par_err); end
`endif
        idle();
        ntest++;
        if (par_err !== 1'b0) begin nfail++; $display("FAIL par_err_pulse: got %b want 0", par_err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_init();
        test_write_read();
        test_stream();
        test_errors();
        test_reset_mid_read();
        test_random();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
